// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR stream encryptor.
// Holds the FSM encoding, tap table and ASCII window.
package lfsr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    MSG,
    PAD,
    DONE
  } state_t;

  localparam logic [5:0] TAP_TABLE [6] = '{
    6'h21, 6'h2D, 6'h30,
    6'h33, 6'h36, 6'h39
  };

  localparam logic [2:0] TAP_MAX   = 3'd5;
  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h5F;

  function automatic logic [5:0] tap_lookup(
    input logic [2:0] sel
  );
    case (sel)
      3'd0:    return TAP_TABLE[0];
      3'd1:    return TAP_TABLE[1];
      3'd2:    return TAP_TABLE[2];
      3'd3:    return TAP_TABLE[3];
      3'd4:    return TAP_TABLE[4];
      3'd5:    return TAP_TABLE[5];
      default: return 6'h00;
    endcase
  endfunction

  // Wraps modulo 64, so out-of-window bytes still encode.
  function automatic logic [5:0] to_sym(
    input logic [7:0] ch
  );
    return 6'(ch - SPACE);
  endfunction

  function automatic logic in_window(
    input logic [7:0] ch
  );
    return (ch >= SPACE) && (ch <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/lfsr_encrypt_ctrl_lfsr6.sv
// 6-bit Fibonacci LFSR with synchronous seed load.
// Feedback is the parity of the tapped state bits.
module lfsr6 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic [5:0] taps,
  input  logic [5:0] seed,
  output logic [5:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 6'h00;
    end else if (init) begin
      state <= seed;
    end else if (en) begin
      state <= {state[4:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/lfsr_encrypt_ctrl.sv
// Frame FSM: preamble, message, pad; XORs LFSR state onto
// each symbol and advances the LFSR once per transferred beat.
module lfsr_encrypt_ctrl
  import lfsr_pkg::*;
#(
  parameter int PRE_LEN   = 10,
  parameter int TOTAL_LEN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] tap_sel,
  input  logic [5:0] seed,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [6:0] PRE_END = 7'(PRE_LEN);
  localparam logic [6:0] TOT_END = 7'(TOTAL_LEN);

  state_t     st_q, st_d;
  logic [6:0] beat_q, beat_d, beat_nxt;
  logic [5:0] taps_q, taps_d;
  logic       err_q, err_d;
  logic       lfsr_init, lfsr_en;
  logic [5:0] lfsr_st;
  logic [5:0] sym;
  logic       xfer;
  logic       cfg_bad;

  lfsr6 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (lfsr_init),
    .en    (lfsr_en),
    .taps  (taps_q),
    .seed  (seed),
    .state (lfsr_st)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      beat_q <= 7'd0;
      taps_q <= 6'h00;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      beat_q <= beat_d;
      taps_q <= taps_d;
      err_q  <= err_d;
    end
  end

  assign beat_nxt = beat_q + 7'd1;
  assign xfer     = out_valid & out_ready;
  assign cfg_bad  = (tap_sel > TAP_MAX) || (seed == 6'h00);

  always_comb begin
    st_d      = st_q;
    beat_d    = beat_q;
    taps_d    = taps_q;
    err_d     = err_q;
    lfsr_init = 1'b0;
    lfsr_en   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sym       = 6'h00;
    done      = 1'b0;
    busy      = (st_q != IDLE);
    unique case (st_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            taps_d    = tap_lookup(tap_sel);
            beat_d    = 7'd0;
            lfsr_init = 1'b1;
            st_d      = PRE;
          end
        end
      end
      PRE: begin
        out_valid = 1'b1;
        if (xfer) begin
          lfsr_en = 1'b1;
          beat_d  = beat_nxt;
          if (beat_nxt == PRE_END) st_d = MSG;
        end
      end
      MSG: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        sym       = to_sym(in_data);
        if (xfer) begin
          lfsr_en = 1'b1;
          beat_d  = beat_nxt;
          if (!in_window(in_data)) err_d = 1'b1;
          if (in_last) begin
            st_d = (beat_nxt < TOT_END) ? PAD : DONE;
          end else if (beat_nxt == TOT_END) begin
            // Frame full before in_last: truncate.
            err_d = 1'b1;
            st_d  = DONE;
          end
        end
      end
      PAD: begin
        out_valid = 1'b1;
        if (xfer) begin
          lfsr_en = 1'b1;
          beat_d  = beat_nxt;
          if (beat_nxt == TOT_END) st_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign out_data = out_valid ? {2'b00, sym ^ lfsr_st}
                              : 8'h00;
  assign err      = err_q;

endmodule

// File: tb/tb_lfsr_encrypt_ctrl.sv
// Randomized bench for lfsr_encrypt_ctrl against a
// frame-level reference model.
module tb_lfsr_encrypt_ctrl;

  localparam int PRE_LEN   = 10;
  localparam int TOTAL_LEN = 64;
  localparam int BUDGET    = 3000;

  localparam logic [5:0] TB_TAPS [6] = '{
    6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39
  };
  localparam logic [7:0] PRE_REF [7] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h21, 8'h03
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] tap_sel = 3'd0;
  logic [5:0] seed = 6'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad = 0;

  logic [7:0] msg_q [$];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  bit         has_last;
  int         exp_consumed;
  bit         exp_err;
  int         consumed;
  bit         rst_hit;

  lfsr_encrypt_ctrl #(
    .PRE_LEN   (PRE_LEN),
    .TOTAL_LEN (TOTAL_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tap_sel   (tap_sel),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Whole-frame expectation: one symbol per beat, keystream
  // advancing by parity feedback each beat.
  task automatic build_model(input logic [2:0] ts,
                             input logic [5:0] sd);
    logic [5:0] st, tp, sym;
    logic [7:0] c;
    int idx;
    bit msg_over;
    st = sd;
    tp = TB_TAPS[ts];
    idx = 0;
    msg_over = 0;
    exp_q.delete();
    exp_err = 0;
    for (int b = 0; b < TOTAL_LEN; b++) begin
      sym = 6'h00;
      if (b >= PRE_LEN && !msg_over) begin
        c = msg_q[idx];
        sym = 6'(c - 8'h20);
        if (c < 8'h20 || c > 8'h5F) exp_err = 1;
        idx++;
        if (has_last && idx == msg_q.size()) msg_over = 1;
        else if (b == TOTAL_LEN - 1) exp_err = 1;
      end
      exp_q.push_back({2'b00, sym ^ st});
      st = {st[4:0], 1'($countones(st & tp) % 2)};
    end
    exp_consumed = idx;
  endtask

  function automatic logic pick(input int m, input int c);
    if (m == 0) return 1'b1;
    if (m == 2) return (c % 4 == 0) || (c % 4 == 3);
    return ($urandom % 4) != 0;
  endfunction

  task automatic drive_in(input int idx, input bit hold,
                          input int m);
    if (idx >= msg_q.size()) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end else begin
      in_valid = hold || m == 0 || ($urandom % 4) != 0;
      in_data  = msg_q[idx];
      in_last  = has_last && (idx == msg_q.size() - 1);
    end
  endtask

  task automatic run_frame(input logic [2:0] ts,
                           input logic [5:0] sd,
                           input int m,
                           input int rst_beat);
    int idx, cyc, ndone, last_tx, done_cyc, n;
    bit fin, stalled, hold, acc;
    logic [7:0] pd;
    idx = 0; cyc = 0; ndone = 0;
    last_tx = -1; done_cyc = -2;
    fin = 0; stalled = 0; pd = 8'h00;
    rst_hit = 0;
    build_model(ts, sd);
    rx_q.delete();
    @(posedge clk); #1;
    tap_sel = ts; seed = sd; start = 1'b1;
    out_ready = pick(m, 0);
    drive_in(0, 0, m);
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_clr", err, 0);
    chk("busy_go", busy, 1);
    while (!fin && cyc < BUDGET) begin
      @(negedge clk);
      if (stalled) chk("hold", out_data, pd);
      if (ndone > 0) begin
        chk("idle_busy", busy, 0);
        chk("done_1cyc", done, 0);
        fin = 1;
      end
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        last_tx = cyc;
      end
      acc = in_valid && in_ready;
      hold = in_valid && !in_ready;
      stalled = out_valid && !out_ready;
      pd = out_data;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk("done_inrdy", in_ready, 0);
      end
      if (rst_beat >= 0 && rx_q.size() == rst_beat) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_inrdy", in_ready, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_od", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        in_valid = 1'b0;
        start = 1'b0;
        rst_hit = 1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      drive_in(idx, hold, m);
      out_ready = pick(m, cyc);
      start = (m == 1 && ndone == 0) ? (($urandom % 6) == 0) : 1'b0;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("timeout", fin, 1);
    chk("beats", rx_q.size(), TOTAL_LEN);
    n = (rx_q.size() < TOTAL_LEN) ? rx_q.size() : TOTAL_LEN;
    for (int i = 0; i < n; i++)
      chk($sformatf("beat%0d", i), rx_q[i], exp_q[i]);
    chk("consumed", idx, exp_consumed);
    chk("done_cnt", ndone, 1);
    chk("done_at", done_cyc, last_tx + 1);
    chk("err_end", err, exp_err);
    consumed = idx;
  endtask

  task automatic bad_start(input logic [2:0] ts,
                           input logic [5:0] sd);
    @(posedge clk); #1;
    tap_sel = ts; seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bad_err", err, 1);
      chk("bad_busy", busy, 0);
      chk("bad_ov", out_valid, 0);
    end
  endtask

  task automatic check_preamble();
    if (rx_q.size() < 7) begin
      chk("pre_len", rx_q.size(), 7);
    end else begin
      for (int i = 0; i < 7; i++)
        chk($sformatf("pre%0d", i), rx_q[i], PRE_REF[i]);
    end
  endtask

  task automatic set_ab();
    msg_q.delete();
    msg_q.push_back(8'h41);
    msg_q.push_back(8'h42);
    has_last = 1;
  endtask

  initial begin
    #12;
    chk("rst_inrdy0", in_ready, 0);
    chk("rst_ov0", out_valid, 0);
    chk("rst_od0", out_data, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_err0", err, 0);
    @(negedge clk) rst_n = 1'b1;

    set_ab();
    run_frame(3'd2, 6'h01, 0, -1);
    check_preamble();
    chk("pad_beats", TOTAL_LEN - PRE_LEN - consumed, 52);

    run_frame(3'd2, 6'h01, 2, -1);
    msg_q.delete();
    for (int i = 0; i < 20; i++)
      msg_q.push_back(8'($urandom_range(8'h20, 8'h5F)));
    run_frame(3'd4, 6'h2B, 2, -1);

    bad_start(3'd6, 6'h01);
    set_ab();
    run_frame(3'd1, 6'h11, 0, -1);
    bad_start(3'd3, 6'h00);
    run_frame(3'd0, 6'h3F, 1, -1);

    msg_q.delete();
    for (int i = 0; i < 60; i++)
      msg_q.push_back(8'($urandom_range(8'h20, 8'h5F)));
    msg_q[5] = 8'h7A;
    has_last = 0;
    run_frame(3'd5, 6'h05, 0, -1);
    chk("trunc_used", consumed, 54);

    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 60);
      msg_q.delete();
      for (int i = 0; i < len; i++) begin
        if ($urandom % 10 == 0)
          msg_q.push_back(8'($urandom));
        else
          msg_q.push_back(8'($urandom_range(8'h20, 8'h5F)));
      end
      has_last = 1;
      run_frame(3'($urandom_range(0, 5)),
                6'($urandom_range(1, 63)), 1, -1);
    end

    msg_q.delete();
    for (int i = 0; i < 30; i++) msg_q.push_back(8'h30);
    has_last = 1;
    run_frame(3'd2, 6'h01, 0, 20);
    chk("rst_hit", rst_hit, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    set_ab();
    run_frame(3'd2, 6'h01, 0, -1);
    check_preamble();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
